rover_motor_ctrl: RTL

//  Downstream stage of the SLAM decision FSM. Accepts one movement command per handshake
//  (fwd/back/left/right + 3-bit speed) and drives the left and right wheel H-bridges.

---
 rtl/rover_motor_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rover_motor_ctrl.sv
// Two-wheel H-bridge controller: takes movement commands, ramps PWM duty toward per-wheel
// targets, brakes to zero duty before reversing, and stops on a command watchdog timeout.
module rover_motor_ctrl #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_fwd,
  input  logic       cmd_back,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic [2:0] cmd_speed,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       motor_en,
  output logic       busy,
  output logic       fault_timeout
);

  localparam int unsigned RampW = $clog2(RAMP_DIV + 1);
  localparam int unsigned WdW   = $clog2(TIMEOUT_CYC + 1);

  typedef logic [PWM_BITS-1:0] duty_t;
  typedef enum logic [1:0] {StIdle, StRun, StBrake, StFault} state_e;

  state_e           state_q, state_d;
  duty_t            duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  duty_t            tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  duty_t            pend_tgt_l_q, pend_tgt_l_d, pend_tgt_r_q, pend_tgt_r_d;
  logic             dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic             pend_dir_l_q, pend_dir_l_d, pend_dir_r_q, pend_dir_r_d;
  logic [RampW-1:0] ramp_cnt_q;
  logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;
  duty_t            pwm_cnt_q;
  logic             pwm_l_q, pwm_r_q;

  duty_t base, cmd_tgt_l, cmd_tgt_r;
  logic  cmd_dir_l, cmd_dir_r;
  logic  accept, ramp_tick, wd_expired, reversal, duties_zero, tgts_zero, cmd_nonzero;

  function automatic duty_t ramp_step(duty_t cur, duty_t tgt);
    if (cur < tgt) return cur + duty_t'(1);
    if (cur > tgt) return cur - duty_t'(1);
    return cur;
  endfunction

  // Command decode; any contradictory or empty command means stop with directions kept.
  always_comb begin
    base      = duty_t'(cmd_speed) << (PWM_BITS - 3);
    cmd_dir_l = dir_l_q;
    cmd_dir_r = dir_r_q;
    cmd_tgt_l = '0;
    cmd_tgt_r = '0;
    if (cmd_speed != 3'd0 && !(cmd_fwd && cmd_back) && !(cmd_left && cmd_right)) begin
      if (cmd_fwd || cmd_back) begin
        cmd_dir_l = cmd_fwd;
        cmd_dir_r = cmd_fwd;
        cmd_tgt_l = cmd_left  ? (base >> 1) : base;
        cmd_tgt_r = cmd_right ? (base >> 1) : base;
      end else if (cmd_left || cmd_right) begin
        cmd_dir_l = cmd_right;
        cmd_dir_r = cmd_left;
        cmd_tgt_l = base;
        cmd_tgt_r = base;
      end
    end
  end

  assign cmd_ready   = ~reset & (state_q != StBrake);
  assign accept      = cmd_valid & cmd_ready;
  assign ramp_tick   = (ramp_cnt_q == RampW'(RAMP_DIV - 1));
  assign wd_expired  = (wd_cnt_q == WdW'(TIMEOUT_CYC - 1));
  assign duties_zero = (duty_l_q == '0) && (duty_r_q == '0);
  assign tgts_zero   = (tgt_l_q == '0) && (tgt_r_q == '0);
  assign cmd_nonzero = (cmd_tgt_l != '0) || (cmd_tgt_r != '0);
  assign reversal    = ((cmd_dir_l != dir_l_q) && (duty_l_q != '0)) ||
                       ((cmd_dir_r != dir_r_q) && (duty_r_q != '0));

  always_comb begin
    state_d      = state_q;
    duty_l_d     = duty_l_q;
    duty_r_d     = duty_r_q;
    tgt_l_d      = tgt_l_q;
    tgt_r_d      = tgt_r_q;
    dir_l_d      = dir_l_q;
    dir_r_d      = dir_r_q;
    pend_tgt_l_d = pend_tgt_l_q;
    pend_tgt_r_d = pend_tgt_r_q;
    pend_dir_l_d = pend_dir_l_q;
    pend_dir_r_d = pend_dir_r_q;
    wd_cnt_d     = '0;

    // Ramp uses the registered targets, so a new target only bites at the next tick.
    if ((state_q == StRun || state_q == StBrake) && ramp_tick) begin
      duty_l_d = ramp_step(duty_l_q, tgt_l_q);
      duty_r_d = ramp_step(duty_r_q, tgt_r_q);
    end

    unique case (state_q)
      StIdle, StFault: begin
        if (accept) begin
          dir_l_d = cmd_dir_l;
          dir_r_d = cmd_dir_r;
          tgt_l_d = cmd_tgt_l;
          tgt_r_d = cmd_tgt_r;
          state_d = cmd_nonzero ? StRun : StIdle;
        end
      end
      StRun: begin
        if (accept) begin
          if (reversal) begin
            pend_dir_l_d = cmd_dir_l;
            pend_dir_r_d = cmd_dir_r;
            pend_tgt_l_d = cmd_tgt_l;
            pend_tgt_r_d = cmd_tgt_r;
            tgt_l_d      = '0;
            tgt_r_d      = '0;
            state_d      = StBrake;
          end else begin
            dir_l_d = cmd_dir_l;
            dir_r_d = cmd_dir_r;
            tgt_l_d = cmd_tgt_l;
            tgt_r_d = cmd_tgt_r;
          end
        end else if (wd_expired) begin
          duty_l_d = '0;
          duty_r_d = '0;
          tgt_l_d  = '0;
          tgt_r_d  = '0;
          state_d  = StFault;
        end else if (tgts_zero && duties_zero) begin
          state_d = StIdle;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      StBrake: begin
        if (wd_expired) begin
          duty_l_d = '0;
          duty_r_d = '0;
          tgt_l_d  = '0;
          tgt_r_d  = '0;
          state_d  = StFault;
        end else if (duties_zero) begin
          dir_l_d = pend_dir_l_q;
          dir_r_d = pend_dir_r_q;
          tgt_l_d = pend_tgt_l_q;
          tgt_r_d = pend_tgt_r_q;
          state_d = ((pend_tgt_l_q != '0) || (pend_tgt_r_q != '0)) ? StRun : StIdle;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      duty_l_q     <= '0;
      duty_r_q     <= '0;
      tgt_l_q      <= '0;
      tgt_r_q      <= '0;
      dir_l_q      <= 1'b1;
      dir_r_q      <= 1'b1;
      pend_tgt_l_q <= '0;
      pend_tgt_r_q <= '0;
      pend_dir_l_q <= 1'b1;
      pend_dir_r_q <= 1'b1;
      wd_cnt_q     <= '0;
      ramp_cnt_q   <= '0;
      pwm_cnt_q    <= '0;
      pwm_l_q      <= 1'b0;
      pwm_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_l_q     <= duty_l_d;
      duty_r_q     <= duty_r_d;
      tgt_l_q      <= tgt_l_d;
      tgt_r_q      <= tgt_r_d;
      dir_l_q      <= dir_l_d;
      dir_r_q      <= dir_r_d;
      pend_tgt_l_q <= pend_tgt_l_d;
      pend_tgt_r_q <= pend_tgt_r_d;
      pend_dir_l_q <= pend_dir_l_d;
      pend_dir_r_q <= pend_dir_r_d;
      wd_cnt_q     <= wd_cnt_d;
      ramp_cnt_q   <= ramp_tick ? '0 : ramp_cnt_q + 1'b1;
      pwm_cnt_q    <= pwm_cnt_q + 1'b1;
      pwm_l_q      <= (pwm_cnt_q < duty_l_q);
      pwm_r_q      <= (pwm_cnt_q < duty_r_q);
    end
  end

  assign motor_en      = (state_q == StRun) || (state_q == StBrake);
  assign busy          = (state_q != StIdle);
  assign fault_timeout = (state_q == StFault);
  assign pwm_l         = pwm_l_q & motor_en;
  assign pwm_r         = pwm_r_q & motor_en;
  // Direction flops reset to forward, but the pins stay low while reset is held.
  assign dir_l         = dir_l_q & ~reset;
  assign dir_r         = dir_r_q & ~reset;

endmodule
